ir_prefetch: RTL and testbench

//  Parametrised instruction register with a prefetch queue for the PDUA datapath.

---
 rtl/ir_prefetch_if.sv | 21 ++
 rtl/ir_prefetch.sv | 84 ++++++++
 tb/tb_ir_prefetch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ir_prefetch_if.sv
// Fetch-side valid/ready bus feeding the instruction prefetch queue.
// The memory/fetch unit is the master; ir_prefetch is the slave.
interface ir_prefetch_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] d;

    modport master (
        output in_valid,
        output d,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  d,
        output in_ready
    );
endinterface

// File: rtl/ir_prefetch.sv
// Instruction register with a DEPTH-entry prefetch FIFO for the PDUA datapath.
// The head word loads into the IR on ena; sclr flushes queue and IR on a branch.
module ir_prefetch #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 5,
    parameter int DEPTH        = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sclr,
    ir_prefetch_if.slave                     fetch,
    input  logic                             ena,
    output logic                             ir_valid,
    output logic [OPCODE_WIDTH-1:0]          opcode,
    output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand,
    output logic [$clog2(DEPTH+1)-1:0]       count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ir;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  push;
    logic                  pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fetch.in_ready = (count_q < CW'(DEPTH));
    assign push = fetch.in_valid & fetch.in_ready;
    assign pop  = ena & (count_q != '0);

    always_ff @(posedge clk) begin
        if (push && !sclr) begin
            mem[wr_ptr] <= fetch.d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
        end else if (sclr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // An ena against an empty queue is a bubble: IR keeps its word.
            if (ena) begin
                if (pop) begin
                    ir       <= mem[rd_ptr];
                    ir_valid <= 1'b1;
                end else begin
                    ir_valid <= 1'b0;
                end
            end
        end
    end

    assign count   = count_q;
    assign opcode  = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign operand = ir[DATA_WIDTH-OPCODE_WIDTH-1:0];
endmodule

// File: tb/tb_ir_prefetch.sv
// Directed vector bench for ir_prefetch (DATA_WIDTH=8, OPCODE_WIDTH=5, DEPTH=2).
// Table of per-cycle stimulus/expectations plus an async mid-stream reset sequence.
module tb_ir_prefetch;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclr = 1'b0;
    logic       ena = 1'b0;
    logic       ir_valid;
    logic [4:0] opcode;
    logic [2:0] operand;
    logic [1:0] count;

    int checks = 0;
    int errors = 0;

    ir_prefetch_if #(.DATA_WIDTH(8)) fbus ();

    ir_prefetch #(
        .DATA_WIDTH  (8),
        .OPCODE_WIDTH(5),
        .DEPTH       (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sclr    (sclr),
        .fetch   (fbus),
        .ena     (ena),
        .ir_valid(ir_valid),
        .opcode  (opcode),
        .operand (operand),
        .count   (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sclr;
        logic       iv;
        logic [7:0] d;
        logic       ena;
        int         cnt;
        logic       rdy;
        logic       irv;
        logic [4:0] op;
        logic [2:0] opd;
    } vec_t;

    localparam int NV = 17;
    vec_t v [NV];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int cnt, input logic rdy,
                             input logic irv, input logic [4:0] op,
                             input logic [2:0] opd);
        check({tag, ".count"}, int'(count), cnt);
        check({tag, ".in_ready"}, int'(fbus.in_ready), int'(rdy));
        check({tag, ".ir_valid"}, int'(ir_valid), int'(irv));
        check({tag, ".opcode"}, int'(opcode), int'(op));
        check({tag, ".operand"}, int'(operand), int'(opd));
    endtask

    task automatic step(input logic s, input logic iv, input logic [7:0] dd,
                        input logic e);
        sclr         = s;
        fbus.in_valid = iv;
        fbus.d        = dd;
        ena          = e;
        @(posedge clk);
        #1;
        sclr         = 1'b0;
        fbus.in_valid = 1'b0;
        ena          = 1'b0;
    endtask

    initial begin
        //            sclr iv  d      ena cnt rdy irv op     opd
        v[0]  = '{1'b0, 1'b1, 8'hA8, 1'b0, 1, 1'b1, 1'b0, 5'h00, 3'd0};
        v[1]  = '{1'b0, 1'b1, 8'h13, 1'b0, 2, 1'b0, 1'b0, 5'h00, 3'd0};
        v[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 2, 1'b0, 1'b0, 5'h00, 3'd0};
        v[3]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1, 1'b1, 1'b1, 5'h15, 3'd0};
        v[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 5'h02, 3'd3};
        v[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 5'h02, 3'd3};
        v[6]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1, 1'b1, 1'b0, 5'h02, 3'd3};
        v[7]  = '{1'b0, 1'b1, 8'h44, 1'b1, 1, 1'b1, 1'b1, 5'h0A, 3'd5};
        v[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 5'h08, 3'd4};
        v[9]  = '{1'b0, 1'b1, 8'h66, 1'b0, 1, 1'b1, 1'b1, 5'h08, 3'd4};
        v[10] = '{1'b0, 1'b1, 8'h77, 1'b0, 2, 1'b0, 1'b1, 5'h08, 3'd4};
        v[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 5'h0C, 3'd6};
        v[12] = '{1'b0, 1'b1, 8'h88, 1'b0, 2, 1'b0, 1'b1, 5'h0C, 3'd6};
        v[13] = '{1'b1, 1'b1, 8'h99, 1'b1, 0, 1'b1, 1'b0, 5'h00, 3'd0};
        v[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 5'h00, 3'd0};
        v[15] = '{1'b0, 1'b1, 8'hF1, 1'b0, 1, 1'b1, 1'b0, 5'h00, 3'd0};
        v[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 5'h1E, 3'd1};

        fbus.in_valid = 1'b0;
        fbus.d        = 8'h00;
        #12;
        check_all("reset", 0, 1'b1, 1'b0, 5'h00, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset", 0, 1'b1, 1'b0, 5'h00, 3'd0);

        for (int i = 0; i < NV; i++) begin
            step(v[i].sclr, v[i].iv, v[i].d, v[i].ena);
            check_all($sformatf("v%0d", i), v[i].cnt, v[i].rdy, v[i].irv,
                      v[i].op, v[i].opd);
        end

        // Mid-stream async reset: IR loaded, one word queued.
        step(1'b0, 1'b1, 8'hB2, 1'b0);
        step(1'b0, 1'b1, 8'hC5, 1'b1);
        check_all("pre_rst", 1, 1'b1, 1'b1, 5'h16, 3'd2);
        #3;
        rst = 1'b0;
        #1;
        check_all("async_rst", 0, 1'b1, 1'b0, 5'h00, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        // The dropped word 0xC5 must not reappear.
        step(1'b0, 1'b1, 8'h2F, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_all("after_rst", 0, 1'b1, 1'b1, 5'h05, 3'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
